// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART receive controller.
//   - parity-mode encodings for the PARITY parameter
//   - receiver FSM state encoding
//   - bit positions inside the status word
//   - helper computing the expected parity bit
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } rx_state_t;

  localparam int STAT_NOT_EMPTY = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_OVERRUN   = 2;
  localparam int STAT_FERR      = 3;
  localparam int STAT_PERR      = 4;
  localparam int STAT_COUNT_LSB = 8;
  localparam int STAT_COUNT_W   = 9;

  // data_xor is the XOR of all data bits; returns the parity bit a
  // well-formed frame carries in the given mode.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    parity_bit = (mode == PAR_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count.
//   clk, rst        : clock, async active-high reset (pointers/count only)
//   i_push, i_wdata : write request and data (ignored when full unless
//                     a pop happens in the same cycle)
//   i_pop           : read request (ignored when empty)
//   o_rdata         : head entry, valid while not empty
//   o_full, o_empty : occupancy flags
//   o_count         : entries held, 0..DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receiver with receive FIFO and register read port.
//   clk, rst             : clock, async active-high reset
//   uart_rx_serial_input : asynchronous serial line, idles high
//   read_enable          : one-cycle read strobe
//   addr_sel             : 0 data register (pops), 1 status (clears sticky)
//   read_data            : combinational read bus, 0 when not reading
//   rx_irq               : registered FIFO-not-empty flag
//
// state   | meaning
// IDLE    | line idle, waiting for a low level
// START   | half-bit wait, confirm start bit at its centre
// DATA    | sampling DATA_BITS bits LSB first at bit centres
// PAR     | sampling the parity bit
// STOP    | sampling STOP_BITS stop bits, push frame after the last
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 10416,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx_serial_input,
  input  logic        read_enable,
  input  logic        addr_sel,
  output logic [31:0] read_data,
  output logic        rx_irq
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          WIDTH     = DATA_BITS + 2;
  localparam logic [15:0] HALF_M1   = 16'(BAUD_DIV/2 - 1);
  localparam logic [15:0] BIT_M1    = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]  STOP_LAST = 4'(STOP_BITS - 1);

  logic                 r_sync1, r_sync2;
  rx_state_t            r_state, w_state_nxt;
  logic [15:0]          r_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr, r_ferr;
  logic                 r_push;
  logic [WIDTH-1:0]     r_push_data;
  logic                 r_sticky_ovr, r_sticky_ferr, r_sticky_perr;
  logic                 r_irq;

  logic                 w_rx, w_tick, w_frame_done;
  logic                 w_pop, w_drop, w_status_rd;
  logic [WIDTH-1:0]     w_rdata;
  logic                 w_full, w_empty;
  logic [AW:0]          w_count;

  assign w_rx   = r_sync2;
  assign w_tick = (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= uart_rx_serial_input;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_frame_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (!w_rx) w_state_nxt = ST_START;
      ST_START: if (w_tick) w_state_nxt = w_rx ? ST_IDLE : ST_DATA;
      ST_DATA:  if (w_tick && r_bit_cnt == DATA_LAST)
                  w_state_nxt = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      ST_PAR:   if (w_tick) w_state_nxt = ST_STOP;
      ST_STOP:  if (w_tick && r_bit_cnt == STOP_LAST) begin
                  w_state_nxt  = ST_IDLE;
                  w_frame_done = 1'b1;
                end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit timer is a down-counter: START loads a half bit, later states a full bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_cnt     <= HALF_M1;
          r_bit_cnt <= '0;
          r_perr    <= 1'b0;
          r_ferr    <= 1'b0;
        end
        ST_DATA: begin
          if (w_tick) begin
            r_cnt     <= BIT_M1;
            r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= (r_bit_cnt == DATA_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
          end else r_cnt <= r_cnt - 16'd1;
        end
        ST_PAR: begin
          if (w_tick) begin
            r_cnt  <= BIT_M1;
            r_perr <= (w_rx != parity_bit(^r_shift, PARITY));
          end else r_cnt <= r_cnt - 16'd1;
        end
        ST_STOP: begin
          if (w_tick) begin
            r_cnt     <= BIT_M1;
            r_bit_cnt <= r_bit_cnt + 4'd1;
            if (!w_rx) r_ferr <= 1'b1;
          end else r_cnt <= r_cnt - 16'd1;
        end
        default: begin
          if (w_tick) r_cnt <= BIT_M1;
          else        r_cnt <= r_cnt - 16'd1;
        end
      endcase
    end
  end

  // The push is registered so the FIFO write lands one clock after the last
  // stop-bit sample; rx_irq follows a clock later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_push      <= 1'b0;
      r_push_data <= '0;
    end else begin
      r_push <= w_frame_done;
      if (w_frame_done) r_push_data <= {r_perr, r_ferr | ~w_rx, r_shift};
    end
  end

  assign w_pop       = read_enable && !addr_sel && !w_empty;
  assign w_status_rd = read_enable && addr_sel;
  assign w_drop      = r_push && w_full && !w_pop;

  sync_fifo #(.WIDTH(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_push),
    .i_wdata (r_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Sticky flags: a new event in the clearing cycle wins over the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sticky_ovr  <= 1'b0;
      r_sticky_ferr <= 1'b0;
      r_sticky_perr <= 1'b0;
      r_irq         <= 1'b0;
    end else begin
      r_sticky_ovr  <= w_drop | (r_sticky_ovr & ~w_status_rd);
      r_sticky_ferr <= (r_push & r_push_data[DATA_BITS]) | (r_sticky_ferr & ~w_status_rd);
      r_sticky_perr <= (r_push & r_push_data[DATA_BITS+1]) | (r_sticky_perr & ~w_status_rd);
      r_irq         <= ~w_empty;
    end
  end

  assign rx_irq = r_irq;

  always_comb begin
    read_data = '0;
    if (read_enable) begin
      if (addr_sel) begin
        read_data[STAT_NOT_EMPTY] = ~w_empty;
        read_data[STAT_FULL]      = w_full;
        read_data[STAT_OVERRUN]   = r_sticky_ovr;
        read_data[STAT_FERR]      = r_sticky_ferr;
        read_data[STAT_PERR]      = r_sticky_perr;
        read_data[STAT_COUNT_LSB +: STAT_COUNT_W] = STAT_COUNT_W'(w_count);
      end else if (w_empty) begin
        read_data = 32'hFFFF_FFFF;
      end else begin
        read_data[7:0] = 8'(w_rdata[DATA_BITS-1:0]);
        read_data[8]   = w_rdata[DATA_BITS];
        read_data[9]   = w_rdata[DATA_BITS+1];
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl.
//   u_dut_a : 8N1, 16-entry FIFO (baseline, framing, glitch, overflow, reset)
//   u_dut_b : 8E1, 4-entry FIFO (parity)
// Register reads push their expected word into a per-instance queue; the
// monitor pops and compares whenever a read strobe is presented.
module tb_uart_rx_ctrl;
  localparam int BAUD = 16;
  localparam int HALF = BAUD / 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_a = 1'b1, line_b = 1'b1;
  logic        re_a = 1'b0, re_b = 1'b0;
  logic        sel_a = 1'b0, sel_b = 1'b0;
  logic [31:0] rd_a, rd_b;
  logic        irq_a, irq_b;

  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  int          last_e = 0;
  logic [31:0] exp_q_a[$];
  logic [31:0] exp_q_b[$];
  logic [31:0] e_a, e_b;

  uart_rx_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_dut_a (
    .clk(clk), .rst(rst), .uart_rx_serial_input(line_a), .read_enable(re_a),
    .addr_sel(sel_a), .read_data(rd_a), .rx_irq(irq_a)
  );

  uart_rx_ctrl #(.BAUD_DIV(BAUD), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_b (
    .clk(clk), .rst(rst), .uart_rx_serial_input(line_b), .read_enable(re_b),
    .addr_sel(sel_b), .read_data(rd_b), .rx_irq(irq_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (re_a) begin
      total++;
      if (exp_q_a.size() == 0) begin
        bad++;
        $display("FAIL rd_a_unexpected got=%h exp=<none>", rd_a);
      end else begin
        e_a = exp_q_a.pop_front();
        if (rd_a !== e_a) begin
          bad++;
          $display("FAIL rd_a sel=%0b got=%h exp=%h", sel_a, rd_a, e_a);
        end
      end
    end
    if (re_b) begin
      total++;
      if (exp_q_b.size() == 0) begin
        bad++;
        $display("FAIL rd_b_unexpected got=%h exp=<none>", rd_b);
      end else begin
        e_b = exp_q_b.pop_front();
        if (rd_b !== e_b) begin
          bad++;
          $display("FAIL rd_b sel=%0b got=%h exp=%h", sel_b, rd_b, e_b);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_read(input bit to_b, input logic sel, input logic [31:0] exp);
    @(posedge clk);
    #1;
    if (to_b) begin
      exp_q_b.push_back(exp); sel_b = sel; re_b = 1'b1;
    end else begin
      exp_q_a.push_back(exp); sel_a = sel; re_a = 1'b1;
    end
    @(posedge clk);
    #1;
    re_a = 1'b0; re_b = 1'b0; sel_a = 1'b0; sel_b = 1'b0;
  endtask

  // Drives start, 8 data bits LSB first, optional parity, one stop bit.
  // last_e is the clock edge at which the receiver samples the stop bit:
  // line edge k = t0+1, bit centre at k+HALF+idx*BAUD, plus 2 synchronizer clocks.
  task automatic send_frame(input bit to_b, input logic [7:0] d, input bit has_par,
                            input logic par, input logic stop, input int limit);
    logic [10:0] bits;
    int nb;
    int t0;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = d[i];
    nb = 9;
    if (has_par) begin
      bits[9] = par;
      nb = 10;
    end
    bits[nb] = stop;
    nb = nb + 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    last_e = t0 + 1 + HALF + (nb - 1) * BAUD + 2;
    for (int b = 0; b < nb && b < limit; b++) begin
      if (to_b) line_b = bits[b];
      else      line_a = bits[b];
      wait_to(t0 + (b + 1) * BAUD);
    end
    line_a = 1'b1;
    line_b = 1'b1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // reset state
    check("irq_a_reset", {31'd0, irq_a}, 32'd0);
    reg_read(0, 1'b1, 32'h0000_0000);
    reg_read(0, 1'b0, 32'hFFFF_FFFF);

    // baseline 0x55 with rx_irq latency of two clocks after the stop sample
    fork
      send_frame(0, 8'h55, 0, 1'b0, 1'b1, 99);
      begin
        @(posedge clk);
        #2;
        wait_to(last_e + 1);
        check("irq_a_e+1", {31'd0, irq_a}, 32'd0);
        wait_to(last_e + 2);
        check("irq_a_e+2", {31'd0, irq_a}, 32'd1);
        check("rd_a_idle_zero", rd_a, 32'd0);
      end
    join
    reg_read(0, 1'b0, 32'h0000_0055);
    reg_read(0, 1'b0, 32'hFFFF_FFFF);
    repeat (2) @(posedge clk);
    #1;
    check("irq_a_drained", {31'd0, irq_a}, 32'd0);

    // framing error
    send_frame(0, 8'hA5, 0, 1'b0, 1'b0, 99);
    reg_read(0, 1'b0, 32'h0000_01A5);
    reg_read(0, 1'b1, 32'h0000_0008);
    reg_read(0, 1'b1, 32'h0000_0000);

    // glitch of BAUD/4
    @(posedge clk);
    #1;
    line_a = 1'b0;
    repeat (BAUD / 4) @(posedge clk);
    #1;
    line_a = 1'b1;
    repeat (2 * BAUD) @(posedge clk);
    reg_read(0, 1'b1, 32'h0000_0000);

    // parity instance: bad parity, then correct parities
    send_frame(1, 8'h03, 1, 1'b1, 1'b1, 99);
    reg_read(1, 1'b0, 32'h0000_0203);
    reg_read(1, 1'b1, 32'h0000_0010);
    reg_read(1, 1'b1, 32'h0000_0000);
    send_frame(1, 8'h03, 1, 1'b0, 1'b1, 99);
    reg_read(1, 1'b0, 32'h0000_0003);
    send_frame(1, 8'h80, 1, 1'b1, 1'b1, 99);
    reg_read(1, 1'b0, 32'h0000_0080);
    reg_read(1, 1'b1, 32'h0000_0000);

    // overflow: 17 frames into 16 entries, 0x20 is dropped
    for (int i = 0; i < 17; i++) send_frame(0, 8'(8'h10 + i), 0, 1'b0, 1'b1, 99);
    reg_read(0, 1'b1, 32'h0000_1007);
    reg_read(0, 1'b1, 32'h0000_1003);

    // push and pop on the same edge while full
    fork
      send_frame(0, 8'hEE, 0, 1'b0, 1'b1, 99);
      begin
        @(posedge clk);
        #2;
        wait_to(last_e);
        exp_q_a.push_back(32'h0000_0010);
        sel_a = 1'b0;
        re_a = 1'b1;
        @(posedge clk);
        #1;
        re_a = 1'b0;
      end
    join
    reg_read(0, 1'b1, 32'h0000_1003);
    for (int i = 1; i < 16; i++) reg_read(0, 1'b0, 32'(8'h10 + i));
    reg_read(0, 1'b0, 32'h0000_00EE);
    reg_read(0, 1'b0, 32'hFFFF_FFFF);

    // reset mid-DATA with a stored entry
    send_frame(0, 8'h77, 0, 1'b0, 1'b1, 99);
    send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 4);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("irq_a_after_rst", {31'd0, irq_a}, 32'd0);
    reg_read(0, 1'b1, 32'h0000_0000);
    reg_read(0, 1'b0, 32'hFFFF_FFFF);
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 99);
    reg_read(0, 1'b0, 32'h0000_003C);

    repeat (2) @(posedge clk);
    check("scoreboard_a_empty", 32'(exp_q_a.size()), 32'd0);
    check("scoreboard_b_empty", 32'(exp_q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
